el2_ifu_axi_rd_resp: RTL and testbench

- AXI4 read-channel responder that serves IFU instruction-fetch bursts from a synchronous 64-bit instruction memory (boot ROM / external SRAM model).
- Sits on the far side of the IFU AR/R bus as the target for fetch misses.
- Accepts AR requests into a small queue and returns in-order R beats with per-beat range checking.
- Supports INCR, WRAP and FIXED bursts.

---
 rtl/el2_ifu_axi_rd_resp.sv | 250 +++++++++++++++++++++++++
 tb/tb_el2_ifu_axi_rd_resp.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/el2_ifu_axi_rd_resp.sv
// AXI4 read-channel responder: serves IFU fetch bursts (FIXED/INCR/WRAP) from a
// synchronous 64-bit memory, returning in-order R beats with per-beat range checks.
`timescale 1ns/1ps
module el2_ifu_axi_rd_resp #(
   parameter int unsigned ID_WIDTH  = 3,
   parameter int unsigned MEM_AW    = 12,
   parameter logic [31:0] BASE_ADDR = 32'hEE00_0000,
   parameter int unsigned AR_DEPTH  = 2
) (
   input  logic                clk,
   input  logic                rst_l,
   input  logic                axi_arvalid,
   output logic                axi_arready,
   input  logic [ID_WIDTH-1:0] axi_arid,
   input  logic [31:0]         axi_araddr,
   input  logic [7:0]          axi_arlen,
   input  logic [2:0]          axi_arsize,
   input  logic [1:0]          axi_arburst,
   output logic                axi_rvalid,
   input  logic                axi_rready,
   output logic [ID_WIDTH-1:0] axi_rid,
   output logic [63:0]         axi_rdata,
   output logic [1:0]          axi_rresp,
   output logic                axi_rlast,
   output logic                mem_rd_en,
   output logic [MEM_AW-1:0]   mem_addr,
   input  logic [63:0]         mem_rd_data
);

   localparam int unsigned QPW     = (AR_DEPTH > 1) ? $clog2(AR_DEPTH) : 1;
   localparam int unsigned QCW     = $clog2(AR_DEPTH + 1);
   localparam int unsigned WIN_LSB = MEM_AW + 3;
   localparam logic [1:0]  BURST_INCR  = 2'b01;
   localparam logic [1:0]  BURST_WRAP  = 2'b10;
   localparam logic [1:0]  RESP_OKAY   = 2'b00;
   localparam logic [1:0]  RESP_SLVERR = 2'b10;

   typedef struct packed {
      logic [ID_WIDTH-1:0] id;
      logic [31:0]         addr;
      logic [7:0]          len;
      logic [2:0]          size;
      logic [1:0]          burst;
   } ar_req_t;

   typedef struct packed {
      logic [ID_WIDTH-1:0] id;
      logic [63:0]         data;
      logic [1:0]          resp;
      logic                last;
   } r_beat_t;

   typedef enum logic {ST_IDLE, ST_BURST} state_e;

   function automatic logic [QPW-1:0] q_ptr_inc(input logic [QPW-1:0] p);
      return (p == QPW'(AR_DEPTH - 1)) ? '0 : p + QPW'(1);
   endfunction

   // Errors that apply to every beat of a burst, decided once at load time.
   function automatic logic burst_error(input ar_req_t r);
      logic [31:0] size_mask;
      size_mask   = (32'd1 << r.size) - 32'd1;
      burst_error = (r.size > 3'd3);
      if (r.burst == BURST_WRAP) begin
         if (!(r.len inside {8'd1, 8'd3, 8'd7, 8'd15})) burst_error = 1'b1;
         if ((r.addr & size_mask) != 32'd0)              burst_error = 1'b1;
      end
   endfunction

   ar_req_t        ar_in, q_head;
   ar_req_t        q_mem [AR_DEPTH];
   logic [QPW-1:0] q_wr_ptr_q, q_rd_ptr_q;
   logic [QCW-1:0] q_cnt_q;
   logic           q_full, q_empty, q_push, q_pop;

   assign ar_in       = {axi_arid, axi_araddr, axi_arlen, axi_arsize, axi_arburst};
   assign q_head      = q_mem[q_rd_ptr_q];
   assign q_full      = (q_cnt_q == QCW'(AR_DEPTH));
   assign q_empty     = (q_cnt_q == '0);
   assign axi_arready = rst_l & ~q_full;
   assign q_push      = axi_arvalid & axi_arready;

   // NOTE: storage arrays have no reset; the occupancy counters gate every use of their contents.
   always_ff @(posedge clk) begin
      if (q_push) q_mem[q_wr_ptr_q] <= ar_in;
   end

   // NOTE: clocked state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         q_wr_ptr_q <= '0;
         q_rd_ptr_q <= '0;
         q_cnt_q    <= '0;
      end else begin
         if (q_push) q_wr_ptr_q <= q_ptr_inc(q_wr_ptr_q);
         if (q_pop)  q_rd_ptr_q <= q_ptr_inc(q_rd_ptr_q);
         case ({q_push, q_pop})
            2'b10:   q_cnt_q <= q_cnt_q + QCW'(1);
            2'b01:   q_cnt_q <= q_cnt_q - QCW'(1);
            default: ;
         endcase
      end
   end

   state_e              state_q, state_d;
   logic [31:0]         cur_addr_q, cur_addr_d;
   logic [7:0]          len_q, len_d, beat_cnt_q, beat_cnt_d;
   logic [2:0]          size_q, size_d;
   logic [1:0]          burst_q, burst_d;
   logic [ID_WIDTH-1:0] id_q, id_d;
   logic                burst_err_q, burst_err_d;

   logic [31:0] incr, wrap_mask, next_addr, addr_off;
   logic [2:0]  slots_used;
   logic        issue, beat_err, beat_last, r_pop;
   logic [1:0]  r_cnt_q;
   logic        s1_valid_q;

   // A slot freed by this cycle's R pop can be reused at once, keeping back-to-back beats.
   assign r_pop      = axi_rvalid & axi_rready;
   assign slots_used = {1'b0, r_cnt_q} + {2'b0, s1_valid_q} - {2'b0, r_pop};
   assign issue      = (state_q == ST_BURST) && (slots_used < 3'd2);
   assign beat_last  = (beat_cnt_q == len_q);
   assign beat_err   = burst_err_q | (cur_addr_q[31:WIN_LSB] != BASE_ADDR[31:WIN_LSB]);
   assign addr_off   = cur_addr_q - BASE_ADDR;
   assign mem_rd_en  = issue & ~beat_err;
   assign mem_addr   = mem_rd_en ? MEM_AW'(addr_off >> 3) : '0;

   // NOTE: combinational blocks assign defaults first so no path can infer a latch.
   always_comb begin
      incr      = 32'd1 << size_q;
      wrap_mask = (({24'd0, len_q} + 32'd1) << size_q) - 32'd1;
      next_addr = cur_addr_q;
      case (burst_q)
         BURST_INCR: next_addr = cur_addr_q + incr;
         BURST_WRAP: next_addr = (cur_addr_q & ~wrap_mask) | ((cur_addr_q + incr) & wrap_mask);
         default:    ;
      endcase
   end

   always_comb begin
      state_d     = state_q;
      cur_addr_d  = cur_addr_q;
      len_d       = len_q;
      size_d      = size_q;
      burst_d     = burst_q;
      id_d        = id_q;
      burst_err_d = burst_err_q;
      beat_cnt_d  = beat_cnt_q;
      q_pop       = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (!q_empty) begin
               q_pop       = 1'b1;
               cur_addr_d  = q_head.addr;
               len_d       = q_head.len;
               size_d      = q_head.size;
               burst_d     = q_head.burst;
               id_d        = q_head.id;
               burst_err_d = burst_error(q_head);
               beat_cnt_d  = 8'd0;
               state_d     = ST_BURST;
            end
         end
         ST_BURST: begin
            if (issue) begin
               cur_addr_d = next_addr;
               beat_cnt_d = beat_cnt_q + 8'd1;
               if (beat_last) state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         state_q     <= ST_IDLE;
         cur_addr_q  <= '0;
         len_q       <= '0;
         size_q      <= '0;
         burst_q     <= '0;
         id_q        <= '0;
         burst_err_q <= 1'b0;
         beat_cnt_q  <= '0;
      end else begin
         state_q     <= state_d;
         cur_addr_q  <= cur_addr_d;
         len_q       <= len_d;
         size_q      <= size_d;
         burst_q     <= burst_d;
         id_q        <= id_d;
         burst_err_q <= burst_err_d;
         beat_cnt_q  <= beat_cnt_d;
      end
   end

   // Beat attributes travel alongside the memory latency and meet the read data here.
   logic                s1_err_q, s1_last_q;
   logic [ID_WIDTH-1:0] s1_id_q;

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         s1_valid_q <= 1'b0;
         s1_err_q   <= 1'b0;
         s1_last_q  <= 1'b0;
         s1_id_q    <= '0;
      end else begin
         s1_valid_q <= issue;
         s1_err_q   <= beat_err;
         s1_last_q  <= beat_last;
         s1_id_q    <= id_q;
      end
   end

   r_beat_t r_mem [2];
   r_beat_t r_in, r_head;
   logic    r_wr_ptr_q, r_rd_ptr_q;

   assign r_in   = {s1_id_q, s1_err_q ? 64'd0 : mem_rd_data,
                    s1_err_q ? RESP_SLVERR : RESP_OKAY, s1_last_q};
   assign r_head = r_mem[r_rd_ptr_q];

   always_ff @(posedge clk) begin
      if (s1_valid_q) r_mem[r_wr_ptr_q] <= r_in;
   end

   always_ff @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         r_wr_ptr_q <= 1'b0;
         r_rd_ptr_q <= 1'b0;
         r_cnt_q    <= '0;
      end else begin
         if (s1_valid_q) r_wr_ptr_q <= ~r_wr_ptr_q;
         if (r_pop)      r_rd_ptr_q <= ~r_rd_ptr_q;
         case ({s1_valid_q, r_pop})
            2'b10:   r_cnt_q <= r_cnt_q + 2'd1;
            2'b01:   r_cnt_q <= r_cnt_q - 2'd1;
            default: ;
         endcase
      end
   end

   assign axi_rvalid = (r_cnt_q != 2'd0);
   assign axi_rid    = axi_rvalid ? r_head.id   : '0;
   assign axi_rdata  = axi_rvalid ? r_head.data : '0;
   assign axi_rresp  = axi_rvalid ? r_head.resp : '0;
   assign axi_rlast  = axi_rvalid & r_head.last;

endmodule

// File: tb/tb_el2_ifu_axi_rd_resp.sv
// Scoreboard bench for el2_ifu_axi_rd_resp: directed AR bursts push expected beats,
// an R-channel monitor compares every presented beat against the queue head.
`timescale 1ns/1ps
module tb_el2_ifu_axi_rd_resp;
   localparam int          ID_W = 3;
   localparam int          AW   = 12;
   localparam logic [31:0] BASE = 32'hEE00_0000;
   localparam logic [1:0]  FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10;

   logic            clk = 1'b0;
   logic            rst_l = 1'b0;
   logic            axi_arvalid = 1'b0, axi_arready;
   logic [ID_W-1:0] axi_arid = '0;
   logic [31:0]     axi_araddr = '0;
   logic [7:0]      axi_arlen = '0;
   logic [2:0]      axi_arsize = '0;
   logic [1:0]      axi_arburst = '0;
   logic            axi_rvalid, axi_rready = 1'b1;
   logic [ID_W-1:0] axi_rid;
   logic [63:0]     axi_rdata;
   logic [1:0]      axi_rresp;
   logic            axi_rlast;
   logic            mem_rd_en;
   logic [AW-1:0]   mem_addr;
   logic [63:0]     mem_rd_data = '0;

   always #5 clk = ~clk;

   el2_ifu_axi_rd_resp #(.ID_WIDTH(ID_W), .MEM_AW(AW), .BASE_ADDR(BASE), .AR_DEPTH(2)) dut (
      .clk(clk), .rst_l(rst_l),
      .axi_arvalid(axi_arvalid), .axi_arready(axi_arready), .axi_arid(axi_arid),
      .axi_araddr(axi_araddr), .axi_arlen(axi_arlen), .axi_arsize(axi_arsize),
      .axi_arburst(axi_arburst),
      .axi_rvalid(axi_rvalid), .axi_rready(axi_rready), .axi_rid(axi_rid),
      .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rlast(axi_rlast),
      .mem_rd_en(mem_rd_en), .mem_addr(mem_addr), .mem_rd_data(mem_rd_data)
   );

   function automatic logic [63:0] mem_word(input int unsigned idx);
      return {32'hC0DE_0000 + idx, 32'h1357_9BDF ^ (idx << 4)};
   endfunction

   always @(posedge clk) begin
      if (mem_rd_en) mem_rd_data <= mem_word(32'(mem_addr));
   end

   typedef struct packed {
      logic [ID_W-1:0] id;
      logic [1:0]      resp;
      logic            last;
      logic [63:0]     data;
   } beat_t;

   beat_t       exp_q[$];
   int          n_tests = 0, n_fail = 0;
   int unsigned cyc = 0, hs_cyc = 0;
   int unsigned rd_issued = 0, ok_popped = 0, max_out = 0;

   task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
      end
   endtask

   task automatic expect_beat(input logic [ID_W-1:0] id, input int unsigned idx,
                              input bit ok, input bit last);
      beat_t b;
      b.id   = id;
      b.resp = ok ? 2'b00 : 2'b10;
      b.last = last;
      b.data = ok ? mem_word(idx) : 64'd0;
      exp_q.push_back(b);
   endtask

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk or negedge rst_l) begin
      if (!rst_l) begin
         rd_issued <= 0;
         ok_popped <= 0;
      end else begin
         if (mem_rd_en) rd_issued <= rd_issued + 1;
         if (axi_rvalid && axi_rready && axi_rresp == 2'b00) ok_popped <= ok_popped + 1;
      end
   end

   // Monitor: every presented beat must match the head; it retires only on handshake.
   always @(negedge clk) begin
      if (rst_l) begin
         if (rd_issued - ok_popped > max_out) max_out = rd_issued - ok_popped;
         if (axi_rvalid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_beat", 128'({axi_rid, axi_rresp, axi_rlast, axi_rdata}), 128'd0);
            end else begin
               check("rbeat", 128'({axi_rid, axi_rresp, axi_rlast, axi_rdata}), 128'(exp_q[0]));
               if (axi_rready) void'(exp_q.pop_front());
            end
         end
      end
   end

   task automatic send_ar(input logic [ID_W-1:0] id, input logic [31:0] addr,
                          input logic [7:0] len, input logic [2:0] size, input logic [1:0] burst);
      bit ok = 1'b0;
      axi_arvalid = 1'b1;
      axi_arid    = id;
      axi_araddr  = addr;
      axi_arlen   = len;
      axi_arsize  = size;
      axi_arburst = burst;
      for (int n = 0; n < 400; n++) begin
         @(negedge clk);
         if (axi_arready) begin
            ok = 1'b1;
            break;
         end
      end
      check("ar_accepted", 128'(ok), 128'd1);
      @(posedge clk);
      #1;
      hs_cyc      = cyc;
      axi_arvalid = 1'b0;
   endtask

   task automatic wait_drain(input string name);
      for (int n = 0; n < 300; n++) begin
         @(negedge clk);
         if (exp_q.size() == 0) break;
      end
      check(name, 128'(exp_q.size()), 128'd0);
      repeat (3) @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   initial begin
      int unsigned first, last_c, base_rd, rr_cyc;
      logic [5:0]  pat;

      #3;
      check("reset_outputs", 128'({axi_rvalid, axi_rlast, axi_rid, axi_rresp, axi_rdata,
                                   mem_rd_en, mem_addr, axi_arready}), 128'd0);
      repeat (3) @(posedge clk);
      #2 rst_l = 1'b1;
      @(negedge clk);
      check("arready_after_reset", 128'(axi_arready), 128'd1);
      @(posedge clk);
      #1;

      // Single INCR beat and its latency from the AR handshake.
      expect_beat(5, 8, 1, 1);
      send_ar(5, BASE + 32'h40, 8'd0, 3'd3, INCR);
      first = 0;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (axi_rvalid) begin
            first = cyc;
            break;
         end
      end
      check("incr1_latency", 128'(first - hs_cyc), 128'd3);
      wait_drain("incr1_drain");

      // Eight-beat INCR must stream with rvalid high every cycle.
      for (int i = 0; i < 8; i++) expect_beat(2, i, 1, i == 7);
      send_ar(2, BASE, 8'd7, 3'd3, INCR);
      first  = 0;
      last_c = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (axi_rvalid && first == 0) first = cyc;
         if (axi_rvalid && axi_rready && axi_rlast) begin
            last_c = cyc;
            break;
         end
      end
      check("incr8_span", 128'(last_c - first + 1), 128'd8);
      wait_drain("incr8_drain");

      // Narrow INCR (4-byte beats) reads each dword twice.
      expect_beat(1, 2, 1, 0);
      expect_beat(1, 2, 1, 0);
      expect_beat(1, 3, 1, 0);
      expect_beat(1, 3, 1, 1);
      send_ar(1, BASE + 32'h10, 8'd3, 3'd2, INCR);
      wait_drain("narrow_drain");

      // WRAP fetch, then an illegal WRAP length.
      expect_beat(3, 5, 1, 0);
      expect_beat(3, 6, 1, 0);
      expect_beat(3, 7, 1, 0);
      expect_beat(3, 4, 1, 1);
      send_ar(3, BASE + 32'h28, 8'd3, 3'd3, WRAP);
      wait_drain("wrap_drain");
      base_rd = rd_issued;
      for (int i = 0; i < 3; i++) expect_beat(4, 0, 0, i == 2);
      send_ar(4, BASE + 32'h28, 8'd2, 3'd3, WRAP);
      wait_drain("wrap_bad_drain");
      check("wrap_bad_no_mem_rd", 128'(rd_issued - base_rd), 128'd0);

      // Backpressure with rready pattern 1,0,0,1,0,1 repeating.
      for (int i = 0; i < 4; i++) expect_beat(6, 32 + i, 1, i == 3);
      pat = 6'b101001;
      fork
         send_ar(6, BASE + 32'h100, 8'd3, 3'd3, INCR);
         for (int i = 0; i < 24; i++) begin
            @(posedge clk);
            #1 axi_rready = pat[i % 6];
         end
      join
      axi_rready = 1'b1;
      wait_drain("backpressure_drain");

      // Queue full: a stalled burst holds the FSM while two more ARs fill the queue.
      axi_rready = 1'b0;
      for (int i = 0; i < 4; i++) expect_beat(0, 64 + i, 1, i == 3);
      expect_beat(1, 96, 1, 0);
      expect_beat(1, 97, 1, 1);
      expect_beat(2, 98, 1, 0);
      expect_beat(2, 99, 1, 1);
      expect_beat(3, 100, 1, 0);
      expect_beat(3, 101, 1, 1);
      send_ar(0, BASE + 32'h200, 8'd3, 3'd3, INCR);
      repeat (4) @(posedge clk);
      #1;
      send_ar(1, BASE + 32'h300, 8'd1, 3'd3, INCR);
      send_ar(2, BASE + 32'h310, 8'd1, 3'd3, INCR);
      @(negedge clk);
      check("queue_full_arready", 128'(axi_arready), 128'd0);
      @(posedge clk);
      #1;
      rr_cyc = 0;
      fork
         send_ar(3, BASE + 32'h320, 8'd1, 3'd3, INCR);
         begin
            repeat (3) @(posedge clk);
            #1;
            rr_cyc     = cyc;
            axi_rready = 1'b1;
         end
      join
      check("ar3_waited_for_space", 128'(hs_cyc > rr_cyc), 128'd1);
      wait_drain("in_order_drain");

      // Out-of-range FIXED below the window, then a burst crossing the top.
      expect_beat(7, 0, 0, 0);
      expect_beat(7, 0, 0, 1);
      send_ar(7, BASE - 32'h8, 8'd1, 3'd3, FIXED);
      wait_drain("below_window_drain");
      expect_beat(1, 4095, 1, 0);
      expect_beat(1, 0, 0, 1);
      send_ar(1, BASE + 32'h7FF8, 8'd1, 3'd3, INCR);
      wait_drain("top_cross_drain");

      // Asynchronous reset in the middle of a stalled burst.
      axi_rready = 1'b0;
      for (int i = 0; i < 8; i++) expect_beat(2, i, 1, i == 7);
      send_ar(2, BASE, 8'd7, 3'd3, INCR);
      repeat (6) @(negedge clk);
      check("rvalid_before_reset", 128'(axi_rvalid), 128'd1);
      #2 rst_l = 1'b0;
      #1;
      check("reset_async_rvalid_arready", 128'({axi_rvalid, axi_arready}), 128'd0);
      exp_q.delete();
      repeat (2) @(posedge clk);
      #3 rst_l = 1'b1;
      @(negedge clk);
      check("arready_after_midburst_reset", 128'(axi_arready), 128'd1);
      axi_rready = 1'b1;
      repeat (5) @(negedge clk);
      @(posedge clk);
      #1;
      expect_beat(6, 8, 1, 1);
      send_ar(6, BASE + 32'h40, 8'd0, 3'd3, INCR);
      wait_drain("post_reset_drain");

      check("max_outstanding_le_2", 128'(max_out <= 2), 128'd1);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule
